nios_system_pulse_pio: RTL

NIOS_SYSTEM_PULSE_PIO -- requirements
Module: nios_system_pulse_pio

---
 rtl/nios_system_pulse_pio_if.sv | 25 ++
 rtl/nios_system_pulse_pio.sv | 122 ++++++++++++
 2 files changed

// File: rtl/nios_system_pulse_pio_if.sv
// Memory-mapped slave bus of the pulse PIO: 3-bit word address,
// active-low write strobe and combinational 32-bit read data.
interface nios_system_pulse_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios_system_pulse_pio.sv
// Output PIO with SET/CLR access and a one-shot pulse engine that inverts
// masked output bits for a programmed number of cycles, with a sticky DONE irq.
module nios_system_pulse_pio #(
  parameter int                 WIDTH       = 8,
  parameter int                 LEN_W       = 16,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  nios_system_pulse_pio_if.slave bus,
  output logic [WIDTH-1:0]      out_port,
  output logic                  irq
);

  typedef enum logic {IDLE = 1'b0, PULSE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [WIDTH-1:0]   act_q, act_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               irq_en_q, irq_en_d;
  logic               done_q, done_d;

  logic               wr;
  logic               ctrl_wr;
  logic [WIDTH-1:0]   wdata_w;
  logic [31:0]        rdata;

  assign wr      = bus.chipselect & ~bus.write_n;
  assign ctrl_wr = wr && (bus.address == 3'd5);
  assign wdata_w = bus.writedata[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      act_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      act_q    <= act_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
    end
  end

  // Register-file writes; never affect the pulse already in flight.
  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    len_d    = len_q;
    irq_en_d = irq_en_q;
    if (wr) begin
      case (bus.address)
        3'd0:    data_d   = wdata_w;
        3'd1:    data_d   = data_q | wdata_w;
        3'd2:    data_d   = data_q & ~wdata_w;
        3'd3:    mask_d   = wdata_w;
        3'd4:    len_d    = bus.writedata[LEN_W-1:0];
        3'd6:    irq_en_d = bus.writedata[0];
        default: ;
      endcase
    end
  end

  // Pulse FSM; the DONE-setting edge overrides a coincident DONE clear.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (ctrl_wr && bus.writedata[1]) begin
      done_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (ctrl_wr && bus.writedata[0]) begin
          state_d = PULSE;
          act_d   = mask_q;
          cnt_d   = (len_q == '0) ? LEN_W'(1) : len_q;
          done_d  = 1'b0;
        end
      end
      PULSE: begin
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          state_d = IDLE;
          act_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      3'd0:    rdata = 32'(data_q);
      3'd3:    rdata = 32'(mask_q);
      3'd4:    rdata = 32'(len_q);
      3'd5:    rdata = {30'd0, done_q, state_q == PULSE};
      3'd6:    rdata = {31'd0, irq_en_q};
      default: rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign out_port     = data_q ^ act_q;
  assign irq          = done_q & irq_en_q;

endmodule
